// File: rtl/conv_host_bridge.sv
// Host-side responder for the CONV engine: holds the input image and both layer
// memories, answers CONV reads/writes, and sequences load -> start -> run -> dump.
module conv_host_bridge #(
    parameter int DW        = 20,
    parameter int IMG_WORDS = 4096,
    parameter int L1_WORDS  = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    input  logic          restart,
    output logic          done,
    output logic          err,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel
);

    localparam int IAW = $clog2(IMG_WORDS);
    localparam int LAW = $clog2(L1_WORDS);

    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

    state_t         state_reg;
    logic [IAW-1:0] ld_cnt_reg;
    logic [LAW-1:0] dp_cnt_reg;
    logic           seen_busy_reg;
    logic           ready_reg;
    logic           done_reg;
    logic           out_valid_reg;
    logic           err_reg;

    logic [DW-1:0] img_mem [IMG_WORDS];
    logic [DW-1:0] l0_mem  [IMG_WORDS];
    logic [DW-1:0] l1_mem  [L1_WORDS];

    logic load_fire;
    logic dump_fire;
    logic dump_last;
    logic sel_l0;
    logic sel_l1;
    logic illegal_access;

    assign in_ready       = (state_reg == ST_LOAD);
    assign load_fire      = in_ready && in_valid;
    assign dump_last      = (dp_cnt_reg == LAW'(L1_WORDS - 1));
    assign dump_fire      = out_valid_reg && out_ready;
    assign sel_l0         = (csel == SEL_L0);
    assign sel_l1         = (csel == SEL_L1);
    assign illegal_access = (cwr || crd) && !sel_l0 && !sel_l1;

    assign out_valid = out_valid_reg;
    assign out_data  = l1_mem[dp_cnt_reg];
    assign out_last  = out_valid_reg && dump_last;
    assign done      = done_reg;
    assign err       = err_reg;
    assign ready     = ready_reg;

    // CONV sees memory contents with zero latency; a same-cycle write lands at the edge.
    assign idata = img_mem[iaddr[IAW-1:0]];

    always_comb begin
        cdata_rd = '0;
        if (crd && sel_l0) begin
            cdata_rd = l0_mem[caddr_rd[IAW-1:0]];
        end else if (crd && sel_l1) begin
            cdata_rd = l1_mem[caddr_rd[LAW-1:0]];
        end
    end

    // Memory arrays carry no reset so contents survive a mid-job abort.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            img_mem[ld_cnt_reg] <= in_data;
        end
        if (cwr && sel_l0) begin
            l0_mem[caddr_wr[IAW-1:0]] <= cdata_wr;
        end
        if (cwr && sel_l1) begin
            l1_mem[caddr_wr[LAW-1:0]] <= cdata_wr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (illegal_access) begin
            err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_LOAD;
            ld_cnt_reg    <= '0;
            dp_cnt_reg    <= '0;
            seen_busy_reg <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (load_fire) begin
                        ld_cnt_reg <= ld_cnt_reg + 1'b1;
                        if (ld_cnt_reg == IAW'(IMG_WORDS - 1)) begin
                            state_reg     <= ST_START;
                            seen_busy_reg <= 1'b0;
                        end
                    end
                end
                ST_START: begin
                    // busy may already be asserted by the time the start pulse leaves
                    ready_reg     <= 1'b1;
                    seen_busy_reg <= busy;
                    state_reg     <= ST_RUN;
                end
                ST_RUN: begin
                    if (busy) begin
                        seen_busy_reg <= 1'b1;
                    end else if (seen_busy_reg) begin
                        state_reg     <= ST_DUMP;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (dump_fire) begin
                        dp_cnt_reg <= dp_cnt_reg + 1'b1;
                        if (dump_last) begin
                            state_reg     <= ST_DONE;
                            out_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        state_reg  <= ST_LOAD;
                        done_reg   <= 1'b0;
                        dp_cnt_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
